modmul_seq_front_829: RTL and testbench

Sequential shift-add multiplier that sits directly upstream of the mod-829 Barrett reduction stage. It accepts two residues a, b over a valid/ready handshake and computes the full-width integer product a*b, one multiplier bit per cycle. The product is presented on a valid/ready output for the reduction stage to consume. It also flags out-of-range operands (>= Q) so corrupt residues are visible before reduction.

---
 rtl/modmul_seq_front_829.sv | 112 +++++++++++
 tb/tb_modmul_seq_front_829.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/modmul_seq_front_829.sv
// Sequential shift-add multiplier feeding the mod-829 Barrett stage; flags operands >= Q.
// Optional macro MODMUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module modmul_seq_front_829 #(
  parameter int WIDTH = 10,
  parameter int Q     = 829
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_prod,
  output logic                 out_range_err,
  output logic                 busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [WIDTH:0] Q_EXT = (WIDTH + 1)'(Q);

  logic [1:0]           state_reg, state_next;
  logic [WIDTH-1:0]     a_reg, a_next;
  logic [WIDTH-1:0]     b_reg, b_next;
  logic [2*WIDTH-1:0]   acc_reg, acc_next;
  logic [CW-1:0]        cnt_reg, cnt_next;
  logic                 err_reg, err_next;
  logic                 in_ready_reg, in_ready_next;

  logic [2*WIDTH-1:0]   a_ext;
  logic [2*WIDTH-1:0]   partial;
  logic                 accept;
  logic                 range_bad;

  assign a_ext     = {{WIDTH{1'b0}}, a_reg};
  assign partial   = a_ext << cnt_reg;
  assign accept    = in_valid && in_ready_reg;
  assign range_bad = ({1'b0, in_a} >= Q_EXT) || ({1'b0, in_b} >= Q_EXT);

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          a_next     = in_a;
          b_next     = in_b;
          acc_next   = '0;
          cnt_next   = '0;
          err_next   = range_bad;
          state_next = RUN;
`ifdef MODMUL_EARLY_TERM_EN
          if (in_b == '0) state_next = DONE;
`endif
        end
      end
      RUN: begin
        if (b_reg[0]) acc_next = acc_reg + partial;
        b_next   = b_reg >> 1;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST_CNT) state_next = DONE;
`ifdef MODMUL_EARLY_TERM_EN
        if (b_next == '0) state_next = DONE;
`endif
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered so in_ready stays low during reset and rises one edge after release.
  assign in_ready_next = (state_next == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      err_reg      <= 1'b0;
      in_ready_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      acc_reg      <= acc_next;
      cnt_reg      <= cnt_next;
      err_reg      <= err_next;
      in_ready_reg <= in_ready_next;
    end
  end

  assign in_ready      = in_ready_reg;
  assign out_valid     = (state_reg == DONE);
  assign out_prod      = (state_reg == DONE) ? acc_reg : '0;
  assign out_range_err = (state_reg == DONE) && err_reg;
  assign busy          = (state_reg == RUN) || (state_reg == DONE);

endmodule

// File: tb/tb_modmul_seq_front_829.sv
// Scoreboard bench for modmul_seq_front_829: driver pushes expected products, negedge monitor pops and checks.
module tb_modmul_seq_front_829;

  localparam int WIDTH = 10;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  in_a;
  logic [WIDTH-1:0]  in_b;
  logic              out_valid;
  logic              out_ready;
  logic [2*WIDTH-1:0] out_prod;
  logic              out_range_err;
  logic              busy;

  modmul_seq_front_829 #(.WIDTH(WIDTH), .Q(829)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .out_range_err(out_range_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2*WIDTH-1:0] prod;
    logic               err;
    int                 hs;
    int                 lat;
  } item_t;

  item_t q[$];
  int n_cmp = 0;
  int n_bad = 0;
  bit toggle_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edges from the handshake edge (counted as 1) to out_valid high.
  function automatic int exp_lat(input logic [WIDTH-1:0] b);
`ifdef MODMUL_EARLY_TERM_EN
    int bl = 0;
    for (int i = 0; i < WIDTH; i++) if (b[i]) bl = i + 1;
    return bl + 1;
`else
    return WIDTH + 1;
`endif
  endfunction

  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [2*WIDTH-1:0] prod, input logic err, input bit push);
    int guard = 0;
    item_t it;
    @(posedge clk); #1;
    while (!in_ready) begin
      if (toggle_mode) begin
        in_valid = ~in_valid;
        in_a = WIDTH'($urandom);
        in_b = WIDTH'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      guard++;
      if (guard > 300) begin
        chk("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk); #1;
    if (push) begin
      it.prod = prod; it.err = err; it.hs = cyc; it.lat = exp_lat(b);
      q.push_back(it);
    end
    in_valid = 1'b0;
    in_a = WIDTH'($urandom);
    in_b = WIDTH'($urandom);
  endtask

  task automatic drain();
    int guard = 0;
    while (q.size() != 0 && guard < 1000) begin
      @(posedge clk); #1;
      guard++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 0);
      q.delete();
    end
    repeat (3) begin @(posedge clk); #1; end
  endtask

  // Monitor
  bit prev_valid = 0;
  bit ready_chk = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 0;
      ready_chk = 0;
    end else begin
      if (ready_chk) begin
        chk("in_ready_after_accept", in_ready, 1);
        ready_chk = 0;
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", out_valid, 0);
        end else begin
          if (!prev_valid) chk("latency", cyc - q[0].hs + 1, q[0].lat);
          chk("out_prod", out_prod, q[0].prod);
          chk("out_range_err", out_range_err, q[0].err);
          chk("in_ready_in_done", in_ready, 0);
          if (out_ready) begin
            void'(q.pop_front());
            ready_chk = 1;
          end
        end
      end
      prev_valid = out_valid;
    end
  end

  typedef struct { logic [WIDTH-1:0] a; logic [WIDTH-1:0] b; logic [2*WIDTH-1:0] p; logic e; } vec_t;
  vec_t vecs[10] = '{
    '{10'd1,   10'd1,   20'd1,     1'b0},
    '{10'd0,   10'd500, 20'd0,     1'b0},
    '{10'd2,   10'd512, 20'd1024,  1'b0},
    '{10'd100, 10'd100, 20'd10000, 1'b0},
    '{10'd17,  10'd23,  20'd391,   1'b0},
    '{10'd828, 10'd1,   20'd828,   1'b0},
    '{10'd512, 10'd2,   20'd1024,  1'b0},
    '{10'd999, 10'd3,   20'd2997,  1'b1},
    '{10'd64,  10'd64,  20'd4096,  1'b0},
    '{10'd250, 10'd4,   20'd1000,  1'b0}
  };

  initial begin
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_prod", out_prod, 0);
    chk("rst_out_range_err", out_range_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("in_ready_low_at_release", in_ready, 0);
    @(posedge clk); #1;
    chk("in_ready_after_release", in_ready, 1);

    issue(10'd5, 10'd7, 20'd35, 1'b0, 1);
    drain();

    issue(10'd828, 10'd828, 20'd685584, 1'b0, 1);
    issue(10'd829, 10'd1, 20'd829, 1'b1, 1);
    issue(10'd1023, 10'd1023, 20'd1046529, 1'b1, 1);
    drain();

    // Output backpressure for 20 cycles.
    out_ready = 1'b0;
    issue(10'd300, 10'd400, 20'd120000, 1'b0, 1);
    guard = 0;
    while (!out_valid && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("stall_valid_seen", out_valid, 1);
    repeat (20) begin @(posedge clk); #1; end
    chk("stall_busy", busy, 1);
    out_ready = 1'b1;
    drain();

    // Abort mid-RUN with reset.
    issue(10'd12, 10'd34, 20'd408, 1'b0, 0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_prod", out_prod, 0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (25) begin @(posedge clk); #1; end
    chk("abort_idle_busy", busy, 0);
    issue(10'd3, 10'd3, 20'd9, 1'b0, 1);
    drain();

    // Back-to-back with in_valid toggling garbage while busy.
    toggle_mode = 1;
    for (int i = 0; i < 10; i++) issue(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].e, 1);
    toggle_mode = 0;
    drain();

    issue(10'd17, 10'd0, 20'd0, 1'b0, 1);
    issue(10'd9, 10'd1, 20'd9, 1'b0, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
